// File: rtl/sort4_ctrl_pkg.sv
// Shared types and constants for the sort4_ctrl batch sorter.
package sort4_pkg;

   localparam int unsigned DW        = 4;
   localparam int unsigned DEPTH_MIN = 2;
   localparam int unsigned DEPTH_MAX = 8;

   typedef logic [DW-1:0] word_t;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic bit depth_ok(input int unsigned depth);
      return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
   endfunction

endpackage

// File: rtl/sort4_ctrl_if.sv
// Producer/consumer stream bundle for sort4_ctrl: one input stream, one sorted output stream.
interface sort4_ctrl_if;
   import sort4_pkg::*;

   logic  in_valid;
   logic  in_ready;
   word_t in_data;
   logic  out_valid;
   logic  out_ready;
   word_t out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/sort4_ctrl_cmp.sv
// Team 4-bit unsigned magnitude comparator, purely combinational.
module comparator_4bit
   import sort4_pkg::*;
(
   input  word_t i_a,
   input  word_t i_b,
   output logic  o_greater_c,
   output logic  o_equal_c,
   output logic  o_less_c
);

   assign o_greater_c = (i_a >  i_b);
   assign o_equal_c   = (i_a == i_b);
   assign o_less_c    = (i_a <  i_b);

endmodule

// File: rtl/sort4_ctrl.sv
// Load/bubble-sort/drain controller around one shared comparator_4bit.
// Optional swap counter port enabled by defining SORT_SWAP_CNT_EN.
module sort4_ctrl
   import sort4_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH*(DEPTH-1)/2+1)
)(
   input  logic              clk,
   input  logic              rst,
   sort4_ctrl_if.slave       bus,
`ifdef SORT_SWAP_CNT_EN
   output logic [CW-1:0]     swap_count,
`endif
   output logic              busy
);

   localparam int unsigned PW       = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH-1);
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH-2);

   if (!depth_ok(DEPTH)) begin : g_depth_chk
      $error("sort4_ctrl: DEPTH out of range 2..8");
   end

   state_t        r_state, w_state_nxt;
   word_t         r_mem [DEPTH];
   word_t         w_mem_nxt [DEPTH];
   logic [PW-1:0] r_wr_ptr, w_wr_ptr_nxt;
   logic [PW-1:0] r_rd_ptr, w_rd_ptr_nxt;
   logic [PW-1:0] r_idx, w_idx_nxt;
   logic [PW-1:0] r_pass, w_pass_nxt;
   logic [PW-1:0] w_idx_p1;
   logic          r_swapped, w_swapped_nxt;
   logic          r_in_ready, r_out_valid, r_busy;
   word_t         r_out_data, w_out_data_nxt;
   logic          w_greater, w_equal, w_less;
   logic          w_cmp_dbg_unused;
`ifdef SORT_SWAP_CNT_EN
   logic [CW-1:0] r_swap_cnt, w_swap_cnt_nxt;
`endif

   assign w_idx_p1 = r_idx + PW'(1);

   // Single compare resource; only greater steers the swap.
   comparator_4bit u_cmp (
      .i_a         (r_mem[r_idx]),
      .i_b         (r_mem[w_idx_p1]),
      .o_greater_c (w_greater),
      .o_equal_c   (w_equal),
      .o_less_c    (w_less)
   );

   assign w_cmp_dbg_unused = w_equal ^ w_less;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= LOAD;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_mem_nxt     = r_mem;
      w_wr_ptr_nxt  = r_wr_ptr;
      w_rd_ptr_nxt  = r_rd_ptr;
      w_idx_nxt     = r_idx;
      w_pass_nxt    = r_pass;
      w_swapped_nxt = r_swapped;
`ifdef SORT_SWAP_CNT_EN
      w_swap_cnt_nxt = r_swap_cnt;
`endif
      unique case (r_state)
         LOAD: begin
            if (bus.in_valid) begin
               w_mem_nxt[r_wr_ptr] = bus.in_data;
               if (r_wr_ptr == LAST_PTR) begin
                  w_state_nxt   = SORT;
                  w_wr_ptr_nxt  = '0;
                  w_idx_nxt     = '0;
                  w_pass_nxt    = '0;
                  w_swapped_nxt = 1'b0;
`ifdef SORT_SWAP_CNT_EN
                  w_swap_cnt_nxt = '0;
`endif
               end else begin
                  w_wr_ptr_nxt = r_wr_ptr + PW'(1);
               end
            end
         end
         SORT: begin
            if (w_greater) begin
               w_mem_nxt[r_idx]    = r_mem[w_idx_p1];
               w_mem_nxt[w_idx_p1] = r_mem[r_idx];
               w_swapped_nxt       = 1'b1;
`ifdef SORT_SWAP_CNT_EN
               w_swap_cnt_nxt      = r_swap_cnt + CW'(1);
`endif
            end
            // End of pass: finish early if nothing moved this pass.
            if (r_idx == LAST_IDX) begin
               if (!(r_swapped || w_greater) || (r_pass == LAST_IDX)) begin
                  w_state_nxt  = DRAIN;
                  w_rd_ptr_nxt = '0;
               end else begin
                  w_idx_nxt     = '0;
                  w_pass_nxt    = r_pass + PW'(1);
                  w_swapped_nxt = 1'b0;
               end
            end else begin
               w_idx_nxt = w_idx_p1;
            end
         end
         DRAIN: begin
            if (bus.out_ready) begin
               if (r_rd_ptr == LAST_PTR) begin
                  w_state_nxt  = LOAD;
                  w_rd_ptr_nxt = '0;
                  w_wr_ptr_nxt = '0;
               end else begin
                  w_rd_ptr_nxt = r_rd_ptr + PW'(1);
               end
            end
         end
         default: w_state_nxt = LOAD;
      endcase
      w_out_data_nxt = (w_state_nxt == DRAIN) ? w_mem_nxt[w_rd_ptr_nxt] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_idx       <= '0;
         r_pass      <= '0;
         r_swapped   <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_mem       <= w_mem_nxt;
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_idx       <= w_idx_nxt;
         r_pass      <= w_pass_nxt;
         r_swapped   <= w_swapped_nxt;
         r_in_ready  <= (w_state_nxt == LOAD);
         r_out_valid <= (w_state_nxt == DRAIN);
         r_busy      <= (w_state_nxt == SORT);
         r_out_data  <= w_out_data_nxt;
      end
   end

`ifdef SORT_SWAP_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_swap_cnt <= '0;
      else     r_swap_cnt <= w_swap_cnt_nxt;
   end

   assign swap_count = r_swap_cnt;
`endif

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign busy          = r_busy;

endmodule
